// File: rtl/uart_wb_ctrl.sv
// Wishbone master for a 16550-style UART: programs the divisor latch, LCR,
// FCR and IER after reset, then polls LSR and moves bytes between a
// valid/ready TX stream and an RX pulse stream with round-robin service.
module uart_wb_ctrl #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'h07,
  parameter logic [7:0]  IER_VAL     = 8'h00,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       wb_rst_i,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic [3:0] wbm_sel_o,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       init_done,
  output logic       bus_err,
  input  logic       cfg_start
);

  typedef enum logic [3:0] {
    INIT0, INIT1, INIT2, INIT3, INIT4, INIT5,
    IDLE, POLL, WR_THR, RD_RBR, ERR
  } state_t;

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t         state_reg;
  logic           stb_reg;
  logic           we_reg;
  logic [2:0]     adr_reg;
  logic [7:0]     dat_reg;
  logic [TW-1:0]  tmo_reg;
  logic           rr_last_reg;   // 1 = TX was served last, 0 = RX
  logic           tx_ready_reg;
  logic           rx_valid_reg;
  logic [7:0]     rx_data_reg;
  logic           init_done_reg;
  logic           bus_err_reg;

  logic           is_bus;
  logic [2:0]     req_adr;
  logic           req_we;
  logic [7:0]     req_dat;
  logic           tx_ok;
  logic           dr;

  // Register access that each bus-owning state issues.
  always_comb begin
    is_bus  = 1'b1;
    req_adr = 3'd0;
    req_we  = 1'b1;
    req_dat = 8'h00;
    case (state_reg)
      INIT0:   begin req_adr = 3'd3; req_dat = 8'h80; end
      INIT1:   begin req_adr = 3'd0; req_dat = DIVISOR[7:0]; end
      INIT2:   begin req_adr = 3'd1; req_dat = DIVISOR[15:8]; end
      INIT3:   begin req_adr = 3'd3; req_dat = LCR_VAL & 8'h7F; end
      INIT4:   begin req_adr = 3'd2; req_dat = FCR_VAL; end
      INIT5:   begin req_adr = 3'd1; req_dat = IER_VAL; end
      POLL:    begin req_adr = 3'd5; req_we = 1'b0; end
      WR_THR:  begin req_adr = 3'd0; req_dat = tx_data; end
      RD_RBR:  begin req_adr = 3'd0; req_we = 1'b0; end
      default: begin is_bus = 1'b0; req_we = 1'b0; end
    endcase
  end

  // LSR status bits as seen on the ack of the poll read.
  assign tx_ok = wbm_dat_i[5] && tx_valid;
  assign dr    = wbm_dat_i[0];

  // Sequencer: issues one registered bus access per state, advances on ack,
  // aborts on ack timeout, and arbitrates TX/RX service round-robin.
  always_ff @(posedge clock) begin
    if (wb_rst_i) begin
      state_reg     <= INIT0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= 3'd0;
      dat_reg       <= 8'h00;
      tmo_reg       <= '0;
      rr_last_reg   <= 1'b0;
      tx_ready_reg  <= 1'b0;
      rx_valid_reg  <= 1'b0;
      rx_data_reg   <= 8'h00;
      init_done_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      tx_ready_reg <= 1'b0;
      rx_valid_reg <= 1'b0;
      if (stb_reg) begin
        if (wbm_ack_i) begin
          stb_reg <= 1'b0;
          we_reg  <= 1'b0;
          adr_reg <= 3'd0;
          dat_reg <= 8'h00;
          tmo_reg <= '0;
          case (state_reg)
            INIT0: state_reg <= INIT1;
            INIT1: state_reg <= INIT2;
            INIT2: state_reg <= INIT3;
            INIT3: state_reg <= INIT4;
            INIT4: state_reg <= INIT5;
            INIT5: begin
              state_reg     <= IDLE;
              init_done_reg <= 1'b1;
            end
            POLL: begin
              if (tx_ok && dr)
                state_reg <= rr_last_reg ? RD_RBR : WR_THR;
              else if (tx_ok)
                state_reg <= WR_THR;
              else if (dr)
                state_reg <= RD_RBR;
              else
                state_reg <= IDLE;
            end
            WR_THR: begin
              tx_ready_reg <= 1'b1;
              rr_last_reg  <= 1'b1;
              state_reg    <= IDLE;
            end
            RD_RBR: begin
              rx_data_reg  <= wbm_dat_i;
              rx_valid_reg <= 1'b1;
              rr_last_reg  <= 1'b0;
              state_reg    <= IDLE;
            end
            default: state_reg <= IDLE;
          endcase
        end else if (tmo_reg == TMO_LAST) begin
          stb_reg       <= 1'b0;
          we_reg        <= 1'b0;
          adr_reg       <= 3'd0;
          dat_reg       <= 8'h00;
          tmo_reg       <= '0;
          bus_err_reg   <= 1'b1;
          init_done_reg <= 1'b0;
          state_reg     <= ERR;
        end else begin
          tmo_reg <= tmo_reg + 1'b1;
        end
      end else if (cfg_start) begin
        state_reg     <= INIT0;
        init_done_reg <= 1'b0;
      end else if (state_reg == IDLE) begin
        state_reg <= POLL;
      end else if (is_bus) begin
        stb_reg <= 1'b1;
        we_reg  <= req_we;
        adr_reg <= req_adr;
        dat_reg <= req_dat;
      end
    end
  end

  assign wbm_stb_o = stb_reg;
  assign wbm_cyc_o = stb_reg;
  assign wbm_sel_o = stb_reg ? 4'b0001 : 4'b0000;
  assign wbm_we_o  = we_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign tx_ready  = tx_ready_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_data   = rx_data_reg;
  assign init_done = init_done_reg;
  assign bus_err   = bus_err_reg;

endmodule
